// File: rtl/rot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rot_pkg                                                           |
// | Brief  : Shared definitions for the sequential rotate arbiter: FSM state   |
// |          encodings and default datapath geometry.                          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package rot_pkg;

  // Default datapath width and its log2 (rotate-amount width).
  localparam int unsigned C_N_DEFAULT      = 8;
  localparam int unsigned C_LOG2_N_DEFAULT = 3;

  // Controller states: waiting for a request, rotating, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : rot_pkg
`default_nettype wire

// File: rtl/rot_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rot_step                                                          |
// | Brief  : One combinational stage of a logarithmic rotator. When enabled,   |
// |          rotates data_i (ascending index) by N >> (stage_i + 1); otherwise |
// |          passes data_i through.                                            |
// | Ports  : data_i  [0:N-1]  operand                                          |
// |          en_i             apply this stage's rotation                      |
// |          stage_i [SW-1:0] stage index 0..LOG2_N-1                          |
// |          data_o  [0:N-1]  result                                           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rot_step #(
  parameter int N      = 8,
  parameter int LOG2_N = 3,
  parameter int SW     = 3
) (
  input  logic [0:N-1]  data_i,
  input  logic          en_i,
  input  logic [SW-1:0] stage_i,
  output logic [0:N-1]  data_o
);

  // All candidate rotations, one per stage; each is pure wiring.
  // out[i] = in[(i - amt) mod N] with amt = N >> (j + 1).
  logic [0:N-1] rot_w [LOG2_N];
  logic [0:N-1] sel_w;

  for (genvar j = 0; j < LOG2_N; j++) begin : g_stage
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign rot_w[j][i] = data_i[(i + N - (N >> (j + 1))) % N];
    end
  end

  always_comb begin
    sel_w = data_i;
    for (int j = 0; j < LOG2_N; j++) begin
      if (stage_i == SW'(j)) begin
        sel_w = rot_w[j];
      end
    end
    data_o = en_i ? sel_w : data_i;
  end

endmodule : rot_step
`default_nettype wire

// File: rtl/rot_seq_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rot_seq_arb                                                       |
// | Brief  : Two-requester round-robin arbiter in front of a time-shared       |
// |          rotator. An accepted operand is rotated by k over LOG2_N cycles   |
// |          (one binary-weighted stage per cycle) and the result is held      |
// |          until the consumer takes it.                                      |
// | Ports  : clk, rst (async, active high)                                     |
// |          reqX_valid/reqX_ready/reqX_bits[0:N-1]/reqX_k[0:LOG2_N-1], X=0,1  |
// |          out_valid/out_ready/out_bits[0:N-1]/out_id                        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rot_seq_arb
  import rot_pkg::*;
#(
  parameter int N      = C_N_DEFAULT,
  parameter int LOG2_N = C_LOG2_N_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [0:N-1]    req0_bits,
  input  logic [0:LOG2_N-1] req0_k,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [0:N-1]    req1_bits,
  input  logic [0:LOG2_N-1] req1_k,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:N-1]    out_bits,
  output logic            out_id
);

  // Stage counter width: enough for 0..LOG2_N-1 plus one spare bit.
  localparam int SW = $clog2(LOG2_N) + 1;

  state_t            state_q, state_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [0:N-1]      data_q, data_d;
  logic [0:LOG2_N-1] k_q, k_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic [0:N-1]      out_bits_q, out_bits_d;
  logic              out_id_q, out_id_d;

  logic [0:N-1]      step_w;
  logic              grant_w;
  logic              any_valid_w;
  logic              ready0_w, ready1_w;
  logic              last_stage_w;

  // k_q is shifted towards index 0 each stage, so k_q[0] is always the
  // enable bit for the stage currently being applied.
  rot_step #(
    .N      (N),
    .LOG2_N (LOG2_N),
    .SW     (SW)
  ) u_step (
    .data_i  (data_q),
    .en_i    (k_q[0]),
    .stage_i (stage_q),
    .data_o  (step_w)
  );

  // Round robin: with both requesting, favour the one not granted last.
  assign any_valid_w  = req0_valid | req1_valid;
  assign grant_w      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign last_stage_w = (stage_q == SW'(LOG2_N - 1));

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    data_d     = data_q;
    k_d        = k_q;
    id_d       = id_q;
    last_d     = last_q;
    out_bits_d = out_bits_q;
    out_id_d   = out_id_q;
    ready0_w   = 1'b0;
    ready1_w   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid_w) begin
          ready0_w = ~grant_w;
          ready1_w = grant_w;
          data_d   = grant_w ? req1_bits : req0_bits;
          k_d      = grant_w ? req1_k : req0_k;
          id_d     = grant_w;
          last_d   = grant_w;
          stage_d  = '0;
          state_d  = ROT;
        end
      end
      ROT: begin
        data_d = step_w;
        k_d    = k_q << 1;
        if (last_stage_w) begin
          stage_d    = '0;
          out_bits_d = step_w;
          out_id_d   = id_q;
          state_d    = DONE;
        end else begin
          stage_d = stage_q + SW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      data_q     <= '0;
      k_q        <= '0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      out_bits_q <= '0;
      out_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      data_q     <= data_d;
      k_q        <= k_d;
      id_q       <= id_d;
      last_q     <= last_d;
      out_bits_q <= out_bits_d;
      out_id_q   <= out_id_d;
    end
  end

  // The state register already reads IDLE during reset, so readies are
  // additionally masked by rst to keep them low while it is asserted.
  assign req0_ready = ready0_w & ~rst;
  assign req1_ready = ready1_w & ~rst;
  assign out_valid  = (state_q == DONE);
  assign out_bits   = out_bits_q;
  assign out_id     = out_id_q;

endmodule : rot_seq_arb
`default_nettype wire

// File: tb/tb_rot_seq_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_rot_seq_arb                                                    |
// | Brief  : Self-checking bench for rot_seq_arb (N=8): directed vector table, |
// |          arbitration, back-pressure, mid-operation reset, random traffic.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_rot_seq_arb;

  localparam int N      = 8;
  localparam int LOG2_N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [0:N-1] req0_bits, req1_bits;
  logic [0:2]   req0_k, req1_k;
  logic         out_valid, out_ready;
  logic [0:N-1] out_bits;
  logic         out_id;

  int n_cmp = 0;
  int n_err = 0;

  rot_seq_arb #(.N(N), .LOG2_N(LOG2_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_bits  (req0_bits),
    .req0_k     (req0_k),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_bits  (req1_bits),
    .req1_k     (req1_k),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rq;
    logic [0:N-1] bits;
    logic [0:2]   k;
    logic [0:N-1] exp;
  } vec_t;

  // Reference rotation: out[i] = bits[(i - k) mod N].
  function automatic logic [0:N-1] model(input logic [0:N-1] b, input logic [0:2] k);
    logic [0:N-1] r;
    int kk;
    kk = int'(k);
    for (int i = 0; i < N; i++) r[i] = b[(i - kk + N) % N];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_bits = '0; req1_bits = '0; req0_k = '0; req1_k = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Issue one op on requester r, wait for acceptance, check latency and result.
  task automatic run_op(input logic r, input logic [0:N-1] b, input logic [0:2] k,
                        input logic [0:N-1] exp, input string name);
    int cnt;
    if (r) begin req1_valid = 1'b1; req1_bits = b; req1_k = k; end
    else   begin req0_valid = 1'b1; req0_bits = b; req0_k = k; end
    #1;
    cnt = 0;
    while (!(r ? req1_ready : req0_ready) && cnt < 20) begin step(); cnt++; end
    if (cnt >= 20) begin
      check({name, "_accept_timeout"}, 32'(cnt), 32'd0);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin step(); cnt++; end
    check({name, "_latency"}, 32'(cnt), 32'(LOG2_N));
    check({name, "_bits"}, 32'(out_bits), 32'(exp));
    check({name, "_id"}, 32'(out_id), 32'(r));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int acc_cyc[4];
    int acc_id[4];
    int n_acc;
    int cyc;
    logic [0:N-1] hold_bits;
    logic         hold_id;
    logic         saw_valid;
    logic [0:N-1] q_bits[$];
    logic         q_id[$];
    int           done_ops;

    vecs[0] = '{1'b0, 8'b10000000, 3'd0, 8'b10000000};
    vecs[1] = '{1'b0, 8'b10000000, 3'd1, 8'b01000000};
    vecs[2] = '{1'b0, 8'b10000000, 3'd3, 8'b00010000};
    vecs[3] = '{1'b0, 8'b10000000, 3'd7, 8'b00000001};
    vecs[4] = '{1'b1, 8'b11000000, 3'd4, 8'b00001100};
    vecs[5] = '{1'b1, 8'b10110000, 3'd2, 8'b00101100};
    vecs[6] = '{1'b0, 8'b00000011, 3'd1, 8'b10000001};
    vecs[7] = '{1'b1, 8'b11110000, 3'd5, 8'b10000111};
    vecs[8] = '{1'b0, 8'b01010101, 3'd6, 8'b01010101};

    // Reset state, with a request pending to show readies are masked.
    idle_inputs();
    rst = 1'b1;
    req0_valid = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bits", 32'(out_bits), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b0;

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      run_op(vecs[v].rq, vecs[v].bits, vecs[v].k, vecs[v].exp, $sformatf("vec%0d", v));
      step();
    end

    // Both requesting continuously: grants alternate 0,1,0,1 with 5-cycle spacing.
    do_reset();
    req0_valid = 1'b1; req0_bits = 8'b10000000; req0_k = 3'd1;
    req1_valid = 1'b1; req1_bits = 8'b00000001; req1_k = 3'd1;
    out_ready  = 1'b1;
    #1;
    n_acc = 0;
    cyc = 0;
    while (n_acc < 4 && cyc < 60) begin
      if (req0_ready && req1_ready) check("rr_both_ready", 32'd1, 32'd0);
      if (req0_ready || req1_ready) begin
        acc_cyc[n_acc] = cyc;
        acc_id[n_acc]  = req1_ready ? 1 : 0;
        n_acc++;
      end
      step();
      cyc++;
    end
    check("rr_count", 32'(n_acc), 32'd4);
    for (int a = 0; a < 4; a++) begin
      if (a < n_acc) begin
        check($sformatf("rr_id%0d", a), 32'(acc_id[a]), 32'(a % 2));
        if (a > 0) check($sformatf("rr_gap%0d", a), 32'(acc_cyc[a] - acc_cyc[a-1]), 32'd5);
      end
    end
    idle_inputs();
    repeat (6) step();

    // Back-pressure: hold out_ready low 4 cycles in DONE while req0 stays valid.
    do_reset();
    req0_valid = 1'b1; req0_bits = 8'b11000000; req0_k = 3'd3;
    #1;
    check("bp_ready_idle", 32'(req0_ready), 32'd1);
    step();
    cyc = 0;
    while (!out_valid && cyc < 20) begin step(); cyc++; end
    check("bp_latency", 32'(cyc), 32'd3);
    hold_bits = out_bits;
    hold_id   = out_id;
    check("bp_bits", 32'(out_bits), 32'(8'b00011000));
    for (int h = 0; h < 4; h++) begin
      req0_bits = 8'(h * 37);
      req1_valid = 1'b1;
      step();
      check($sformatf("bp_hold_valid%0d", h), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_bits%0d", h), 32'(out_bits), 32'(hold_bits));
      check($sformatf("bp_hold_id%0d", h), 32'(out_id), 32'(hold_id));
      check($sformatf("bp_hold_rdy%0d", h), 32'({req0_ready, req1_ready}), 32'd0);
    end
    req1_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_exit_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
    step();
    out_ready = 1'b0;
    check("bp_consumed", 32'(out_valid), 32'd0);
    check("bp_next_ready", 32'(req0_ready), 32'd1);
    idle_inputs();
    step();
    repeat (4) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset pulse in the middle of ROT abandons the operation.
    do_reset();
    req0_valid = 1'b1; req0_bits = 8'b01100000; req0_k = 3'd2;
    step();
    req0_valid = 1'b0;
    step();
    req0_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_bits", 32'(out_bits), 32'd0);
    check("mr_out_id", 32'(out_id), 32'd0);
    check("mr_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    step();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int w = 0; w < 6; w++) begin
      step();
      if (out_valid) saw_valid = 1'b1;
    end
    check("mr_no_result", 32'(saw_valid), 32'd0);
    run_op(1'b0, 8'b10100000, 3'd3, 8'b00010100, "mr_next");

    // Random traffic against the reference model, in acceptance order.
    do_reset();
    done_ops = 0;
    cyc = 0;
    while (done_ops < 2000 && cyc < 40000) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_bits  = 8'($urandom);
      req1_bits  = 8'($urandom);
      req0_k     = 3'($urandom);
      req1_k     = 3'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      #1;
      if (req0_ready && req1_ready) check("rand_both_ready", 32'd1, 32'd0);
      if (req0_ready) begin q_bits.push_back(model(req0_bits, req0_k)); q_id.push_back(1'b0); end
      if (req1_ready) begin q_bits.push_back(model(req1_bits, req1_k)); q_id.push_back(1'b1); end
      if (out_valid && out_ready) begin
        if (q_bits.size() == 0) begin
          check("rand_unexpected_out", 32'd1, 32'd0);
        end else begin
          check($sformatf("rand_op%0d", done_ops), 32'({out_id, out_bits}),
                32'({q_id.pop_front(), q_bits.pop_front()}));
        end
        done_ops++;
      end
      step();
      cyc++;
    end
    check("rand_ops_done", 32'(done_ops), 32'd2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rot_seq_arb
`default_nettype wire
